// File: rtl/dm_io_pkg.sv
// Shared definitions for the DMInterface pad-input blocks.
// Holds the deglitch filter state encoding and the default
// synchroniser depth and filter length.
package dm_io_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    QUAL_HI = 2'd1,
    ST_HI   = 2'd2,
    QUAL_LO = 2'd3
  } filt_state_e;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int FILTER_CYCLES_DEF = 16;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous pad level.
// Pure flop chain, reset value 0; reused for every DMInterface pad input.
// Only the path from d into the first stage is meant to be constrained
// as asynchronous; stage-to-stage paths are ordinary same-clock paths.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* synchronizer = "true" *) logic [SYNC_STAGES-1:0] sync_q;

  // Shift the pad level through the chain with no logic between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pad_in_deglitch.sv
// Pad input conditioner: synchronises pad_y into the clk domain and only
// accepts a new level after FILTER_CYCLES consecutive matching samples.
// Produces a clean level plus one-cycle rise/fall strobes.
// Optional rising-edge counter is compiled in with PAD_IN_EDGE_COUNT_EN.
// Handshake note: there is no valid/ready interface here; rise_pulse and
// fall_pulse are single-cycle strobes aligned with the first cycle of the
// new level_out value and are never asserted together.
module pad_in_deglitch
  import dm_io_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int CNT_WIDTH     = 16,
  localparam int QW           = $clog2(FILTER_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pad_y,
  input  logic                 count_clr,
  output logic                 level_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
`ifdef PAD_IN_EDGE_COUNT_EN
  output logic [CNT_WIDTH-1:0] edge_count,
`endif
  output filt_state_e          state_dbg,
  output logic [QW-1:0]        qcnt_dbg
);

  localparam logic [QW-1:0] QONE = QW'(1);
  localparam logic [QW-1:0] QMAX = QW'(FILTER_CYCLES);

  logic            s;
  filt_state_e     state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic            level_d, rise_d, fall_d;

  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pad_y),
    .q  (s)
  );

  // Next-state, qualification count and strobe decode for the filter.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_LO: begin
        if (s) begin
          if (FILTER_CYCLES == 1) begin
            state_d = ST_HI;
            qcnt_d  = '0;
            rise_d  = 1'b1;
          end else begin
            state_d = QUAL_HI;
            qcnt_d  = QONE;
          end
        end
      end
      QUAL_HI: begin
        if (!s) begin
          state_d = ST_LO;
          qcnt_d  = '0;
        end else if (qcnt_q + QONE == QMAX) begin
          state_d = ST_HI;
          qcnt_d  = '0;
          rise_d  = 1'b1;
        end else begin
          qcnt_d = qcnt_q + QONE;
        end
      end
      ST_HI: begin
        if (!s) begin
          if (FILTER_CYCLES == 1) begin
            state_d = ST_LO;
            qcnt_d  = '0;
            fall_d  = 1'b1;
          end else begin
            state_d = QUAL_LO;
            qcnt_d  = QONE;
          end
        end
      end
      QUAL_LO: begin
        if (s) begin
          state_d = ST_HI;
          qcnt_d  = '0;
        end else if (qcnt_q + QONE == QMAX) begin
          state_d = ST_LO;
          qcnt_d  = '0;
          fall_d  = 1'b1;
        end else begin
          qcnt_d = qcnt_q + QONE;
        end
      end
      default: begin
        state_d = ST_LO;
        qcnt_d  = '0;
      end
    endcase
    level_d = (state_d == ST_HI) || (state_d == QUAL_LO);
  end

  // Filter state, counter and registered outputs; reset drops everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LO;
      qcnt_q     <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      level_out  <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

`ifdef PAD_IN_EDGE_COUNT_EN
  // Count qualified rising edges; a clear coinciding with a rise leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_count <= '0;
    end else if (count_clr) begin
      edge_count <= rise_pulse ? CNT_WIDTH'(1) : '0;
    end else if (rise_pulse) begin
      edge_count <= edge_count + CNT_WIDTH'(1);
    end
  end
`else
  logic                 unused_count_clr;
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_count_clr = count_clr;
  assign unused_cnt_width = '0;
`endif

  assign state_dbg = state_q;
  assign qcnt_dbg  = qcnt_q;

endmodule

// File: tb/tb_pad_in_deglitch.sv
// Directed bench for pad_in_deglitch with SYNC_STAGES=2, FILTER_CYCLES=4,
// CNT_WIDTH=4. Define PAD_IN_EDGE_COUNT_EN to include the counter steps.
module tb_pad_in_deglitch;
  import dm_io_pkg::*;

  localparam int SS = 2;
  localparam int FC = 4;
  localparam int CW = 4;
  localparam int QW = $clog2(FC + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          pad_y;
  logic          count_clr;
  logic          level_out;
  logic          rise_pulse;
  logic          fall_pulse;
`ifdef PAD_IN_EDGE_COUNT_EN
  logic [CW-1:0] edge_count;
  int            exp_cnt;
`endif
  filt_state_e   state_dbg;
  logic [QW-1:0] qcnt_dbg;

  int n_checks = 0;
  int n_errors = 0;

  pad_in_deglitch #(
    .SYNC_STAGES  (SS),
    .FILTER_CYCLES(FC),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pad_y     (pad_y),
    .count_clr (count_clr),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
`ifdef PAD_IN_EDGE_COUNT_EN
    .edge_count(edge_count),
`endif
    .state_dbg (state_dbg),
    .qcnt_dbg  (qcnt_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Level steady at exp_level with neither strobe active.
  task automatic check_quiet(input string tag, input logic exp_level);
    check({tag, "_level"}, 32'(level_out), 32'(exp_level));
    check({tag, "_rise"},  32'(rise_pulse), 32'd0);
    check({tag, "_fall"},  32'(fall_pulse), 32'd0);
  endtask

  // Drive a clean step to v and expect the output to follow after
  // SS-1+FC edges with the matching one-cycle strobe.
  task automatic qualify_edge(input logic v);
    pad_y = v;
    for (int i = 0; i < SS - 1 + FC; i++) begin
      tick();
      check_quiet("edge_wait", !v);
    end
    tick();
    check("edge_level", 32'(level_out), 32'(v));
    check("edge_rise",  32'(rise_pulse), 32'(v));
    check("edge_fall",  32'(fall_pulse), 32'(!v));
    tick();
    check_quiet("edge_after", v);
  endtask

  initial begin
    rst       = 1'b1;
    pad_y     = 1'b1;
    count_clr = 1'b0;

    // 1. Reset held for 3 cycles with pad high: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("rst_hold", 1'b0);
      check("rst_state", 32'(state_dbg), 32'(ST_LO));
      check("rst_qcnt",  32'(qcnt_dbg), 32'd0);
`ifdef PAD_IN_EDGE_COUNT_EN
      check("rst_cnt", 32'(edge_count), 32'd0);
`endif
    end
    rst = 1'b0;
    qualify_edge(1'b1);
    check("post_rst_state", 32'(state_dbg), 32'(ST_HI));

    // 2. Clean steps in both directions.
    qualify_edge(1'b0);
    qualify_edge(1'b1);
    qualify_edge(1'b0);
    check("step_state", 32'(state_dbg), 32'(ST_LO));

    // 3a. Three-cycle pulse is rejected.
    pad_y = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("glitch3", 1'b0);
    end
    pad_y = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_quiet("glitch3_tail", 1'b0);
    end
    check("glitch3_state", 32'(state_dbg), 32'(ST_LO));

    // 3b. Four-cycle pulse qualifies, then the fall qualifies too.
    pad_y = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_quiet("pulse4", 1'b0);
    end
    pad_y = 1'b0;
    tick();
    check_quiet("pulse4_k4", 1'b0);
    tick();
    check("pulse4_level", 32'(level_out), 32'd1);
    check("pulse4_rise",  32'(rise_pulse), 32'd1);
    check("pulse4_fall0", 32'(fall_pulse), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("pulse4_hold", 1'b1);
    end
    tick();
    check("pulse4_lvl0", 32'(level_out), 32'd0);
    check("pulse4_fall", 32'(fall_pulse), 32'd1);
    check("pulse4_rise0", 32'(rise_pulse), 32'd0);
    tick();
    check_quiet("pulse4_after", 1'b0);

    // 4. Chatter: toggling every cycle never qualifies.
    for (int i = 0; i < 40; i++) begin
      pad_y = ~pad_y;
      tick();
      check_quiet("chatter", 1'b0);
    end
    pad_y = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("chatter_tail", 1'b0);
    end
    check("chatter_state", 32'(state_dbg), 32'(ST_LO));

    // 6. Reset in QUAL_HI with qcnt=2 abandons the qualification.
    pad_y = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_quiet("midq_wait", 1'b0);
    end
    check("midq_state", 32'(state_dbg), 32'(QUAL_HI));
    check("midq_qcnt",  32'(qcnt_dbg), 32'd2);
    rst = 1'b1;
    tick();
    check_quiet("midq_rst", 1'b0);
    check("midq_rst_state", 32'(state_dbg), 32'(ST_LO));
    check("midq_rst_qcnt",  32'(qcnt_dbg), 32'd0);
    pad_y = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_quiet("midq_after", 1'b0);
    end

`ifdef PAD_IN_EDGE_COUNT_EN
    // 5. Edge counter: wrap, clear coinciding with a rise, plain clear.
    exp_cnt = 0;
    check("cnt_start", 32'(edge_count), 32'd0);
    for (int i = 0; i < 17; i++) begin
      qualify_edge(1'b1);
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      check("cnt_inc", 32'(edge_count), 32'(exp_cnt));
      qualify_edge(1'b0);
    end
    check("cnt_wrap", 32'(edge_count), 32'd1);
    qualify_edge(1'b1);
    check("cnt_two", 32'(edge_count), 32'd2);
    qualify_edge(1'b0);
    pad_y = 1'b1;
    for (int i = 0; i < SS - 1 + FC; i++) begin
      tick();
      check_quiet("clr_rise_wait", 1'b0);
    end
    tick();
    check("clr_rise_pulse", 32'(rise_pulse), 32'd1);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check("clr_with_rise", 32'(edge_count), 32'd1);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check("clr_alone", 32'(edge_count), 32'd0);
    tick();
    check("clr_hold", 32'(edge_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pad_in_deglitch.md
Name: pad_in_deglitch

Overview:
- Consumes the single-bit LVCMOS33 input-buffer output (Y) of a DMInterface pad on the SmartFusion2 fabric.
- Synchronises the asynchronous pad level into the clk domain and rejects glitches with a qualification filter.
- Emits a clean level, single-cycle rise and fall strobes, and, optionally, a rising-edge event count for the register file.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops. Legal range is 2 or more.
- FILTER_CYCLES, 16: consecutive synchronised samples at the new value required before level_out changes. Legal range is 1 or more.
- CNT_WIDTH, 16: width of edge_count. Used only when the counter is compiled in.

Ports:
- clk  in  1: fabric clock.
- rst  in  1: synchronous reset, active-high.
- pad_y  in  1: asynchronous level from the pad input buffer Y.
- count_clr  in  1: synchronous clear of edge_count.
- level_out  out  1: filtered, synchronised pad level.
- rise_pulse  out  1: one-cycle strobe on a qualified 0->1 transition.
- fall_pulse  out  1: one-cycle strobe on a qualified 1->0 transition.
- edge_count  out  CNT_WIDTH: count of qualified rising edges. Present only with PAD_IN_EDGE_COUNT_EN.

Behaviour:
- Clock and reset
  - All state updates on posedge clk.
  - rst is synchronous and active-high and overrides every other input.
- Reset values
  - Synchroniser flops are 0, state is ST_LO and the qualification counter is 0.
  - level_out, rise_pulse and fall_pulse are 0. edge_count is 0.
- Synchroniser
  - pad_y passes through SYNC_STAGES flops; the last stage is called s.
  - No logic sits between the synchroniser stages.
- Filter FSM: ST_LO, QUAL_HI, ST_HI, QUAL_LO.
  - ST_LO: if s=1, load qcnt=1 and go to QUAL_HI. With FILTER_CYCLES=1, go directly to ST_HI instead.
  - QUAL_HI: if s=0, clear qcnt and return to ST_LO with no output activity. Otherwise increment qcnt; when qcnt reaches FILTER_CYCLES, go to ST_HI.
  - ST_HI and QUAL_LO: mirror images of ST_LO and QUAL_HI.
  - qcnt width is clog2(FILTER_CYCLES+1). It never exceeds FILTER_CYCLES.
- Outputs
  - level_out is registered and equals 1 exactly while in ST_HI or QUAL_LO.
  - rise_pulse is 1 for exactly one cycle, the first cycle level_out reads 1. fall_pulse is the same for the first cycle level_out reads 0.
  - rise_pulse and fall_pulse are never asserted together.
- Latency
  - A clean step on pad_y, sampled at edge k, reaches s at edge k+SYNC_STAGES-1.
  - level_out and the strobe change at edge k+SYNC_STAGES-1+FILTER_CYCLES.
- Glitches: any excursion of s shorter than FILTER_CYCLES samples produces no change on level_out and no strobe.
- Reset mid-operation: qualification is abandoned, outputs return to their reset values, and no strobe is emitted.
- Metastability: the synchroniser flops carry the synchronizer attribute; timing is constrained from pad_y to the first stage only.

Optional Feature:
- Macro: PAD_IN_EDGE_COUNT_EN
- When defined:
  - edge_count increments on every cycle rise_pulse=1 and wraps from 2^CNT_WIDTH-1 to 0.
  - count_clr=1 sets edge_count to 0.
  - If count_clr and rise_pulse coincide, edge_count becomes 1.
- When undefined:
  - The edge_count port and its register are absent and count_clr is ignored.
  - All other behaviour is identical.

Decomposition:
- Shared package dm_io_pkg holds:
  - the FSM state enum: ST_LO, QUAL_HI, ST_HI, QUAL_LO;
  - the default constants SYNC_STAGES_DEF=2 and FILTER_CYCLES_DEF=16.
- Sub-module: bit_sync.
  - Parameterised SYNC_STAGES-deep flop chain with the reset value 0.
  - The same module is reused for other DMInterface pad inputs.
- Top level: FSM, qualification counter, strobes and the optional counter.

Test Plan (SYNC_STAGES=2, FILTER_CYCLES=4, CNT_WIDTH=4):
1. Reset: hold rst for 3 cycles with pad_y=1 -> level_out, rise_pulse, fall_pulse and edge_count stay 0 throughout; level_out rises 2+4 edges after rst deasserts and rise_pulse asserts for 1 cycle.
2. Clean step: pad_y goes 0->1 and is held -> level_out=1 at sample edge +5, rise_pulse high for exactly that cycle; 1->0 -> fall_pulse likewise and level_out=0.
3. Glitch: a 3-cycle high pulse on pad_y -> level_out stays 0, no strobes, FSM returns to ST_LO; a 4-cycle pulse -> rise_pulse fires, and the later fall qualifies.
4. Chatter: pad_y toggles every cycle for 40 cycles -> no output activity.
5. PAD_IN_EDGE_COUNT_EN: 17 qualified rising edges -> edge_count=1 after wrap; count_clr in the same cycle as rise_pulse -> edge_count=1; count_clr alone -> 0.
6. Reset mid-qualification: rst asserted while in QUAL_HI with qcnt=2 -> no rise_pulse, all outputs 0 the next cycle.
